// File: rtl/reg_rom_bus.sv
// Register plus small RAM sharing one tri-state data bus, with a preloaded memory image.
// Reads are combinational (same cycle); writes and register loads take effect at the next rising edge.
// No backpressure: the enables decide who drives, and the register wins whenever both enables are high.
module reg_rom_bus #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  inout  wire  [DATA_W-1:0] io_bus,
  input  logic              i_reg_load,
  input  logic              i_reg_enable,
  input  logic              i_reg_only_lower,
  input  logic              i_mem_load,
  input  logic              i_mem_enable,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_reg
);

  localparam int DEPTH = 1 << ADDR_W;

  // Keeps only the low nibble; upper bits are forced to zero in the low-nibble drive mode.
  localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'(4'hF);

  logic [DATA_W-1:0] reg_q;
  logic [DATA_W-1:0] reg_drive;
  logic [DATA_W-1:0] mem_rd;

  // Power-up image. Reset never touches the array, so the image survives until overwritten.
  logic [DATA_W-1:0] mem [DEPTH] = '{
    0:       DATA_W'(8'h5A),
    1:       DATA_W'(8'hE0),
    2:       DATA_W'(8'hF0),
    default: '0
  };

  // Register capture; the async clear also masks loads for as long as reset is held.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      reg_q <= '0;
    end else if (i_reg_load) begin
      reg_q <= io_bus;
    end
  end

  // Memory write; captures whatever the bus carries (including X/Z in simulation) without reset.
  always_ff @(posedge i_clk) begin
    if (i_mem_load) begin
      mem[i_addr] <= io_bus;
    end
  end

  // Register bus value, optionally restricted to the low nibble.
  always_comb begin
    reg_drive = reg_q;
    if (i_reg_only_lower) begin
      reg_drive = reg_q & LOW_MASK;
    end
  end

  assign mem_rd = mem[i_addr];

  // Single bus driver: the register has priority, memory only drives when the register is off,
  // and the bus is released when neither enable is asserted. Reset does not affect this choice.
  assign io_bus = i_reg_enable ? reg_drive :
                  i_mem_enable ? mem_rd    :
                                 {DATA_W{1'bz}};

  assign o_reg = reg_q;

endmodule

// File: tb/tb_reg_rom_bus.sv
module tb_reg_rom_bus;

  logic       clk;
  logic       rst;
  logic       reg_load;
  logic       reg_enable;
  logic       reg_only_lower;
  logic       mem_load;
  logic       mem_enable;
  logic [3:0] addr;
  logic [7:0] o_reg;

  logic       tb_oe;
  logic [7:0] tb_drv;
  wire  [7:0] bus;

  assign bus = tb_oe ? tb_drv : 8'bz;

  reg_rom_bus #(.DATA_W(8), .ADDR_W(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .io_bus           (bus),
    .i_reg_load       (reg_load),
    .i_reg_enable     (reg_enable),
    .i_reg_only_lower (reg_only_lower),
    .i_mem_load       (mem_load),
    .i_mem_enable     (mem_enable),
    .i_addr           (addr),
    .o_reg            (o_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: kind 0 = io_bus, kind 1 = o_reg.
  logic [7:0] exp_q  [$];
  bit         kind_q [$];
  string      name_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic exp_bus(input string name, input logic [7:0] v);
    exp_q.push_back(v);
    kind_q.push_back(1'b0);
    name_q.push_back(name);
  endtask

  task automatic exp_reg(input string name, input logic [7:0] v);
    exp_q.push_back(v);
    kind_q.push_back(1'b1);
    name_q.push_back(name);
  endtask

  // Monitor: on the falling edge, compare every pending expectation with the settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] act;
      bit         k;
      string      nm;
      e   = exp_q.pop_front();
      k   = kind_q.pop_front();
      nm  = name_q.pop_front();
      act = k ? o_reg : bus;
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: %s got %h expected %h", nm, k ? "o_reg" : "io_bus", act, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_load       = 1'b0;
    reg_enable     = 1'b0;
    reg_only_lower = 1'b0;
    mem_load       = 1'b0;
    mem_enable     = 1'b0;
    tb_oe          = 1'b0;
    tb_drv         = 8'h00;
    addr           = 4'd0;
  endtask

  task automatic mem_read(input string name, input logic [3:0] a, input logic [7:0] v);
    idle();
    mem_enable = 1'b1;
    addr       = a;
    exp_bus(name, v);
    tick();
  endtask

  // Load the register from the testbench driving the bus.
  task automatic load_reg(input logic [7:0] v);
    idle();
    tb_oe    = 1'b1;
    tb_drv   = v;
    reg_load = 1'b1;
    tick();
    idle();
  endtask

  logic [3:0] rd_addr [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
  logic [7:0] rd_val  [4] = '{8'h5A, 8'hE0, 8'hF0, 8'h00};

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_reg("reset_oreg", 8'h00);
    tick();
    rst = 1'b1;

    // Initial image reads, register still clear.
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_enable = 1'b1;
      addr       = rd_addr[i];
      exp_bus($sformatf("init_read_a%0d", rd_addr[i]), rd_val[i]);
      exp_reg("init_oreg", 8'h00);
      tick();
    end

    // Memory drives addr0 into the register.
    idle();
    mem_enable = 1'b1;
    reg_load   = 1'b1;
    tick();
    idle();
    exp_reg("mem_to_reg", 8'h5A);
    tick();

    reg_enable     = 1'b1;
    reg_only_lower = 1'b1;
    exp_bus("reg_drive_lower", 8'h0A);
    tick();
    reg_only_lower = 1'b0;
    exp_bus("reg_drive_full", 8'h5A);
    exp_reg("reg_drive_oreg", 8'h5A);
    tick();

    // Testbench writes 0x3C into addr7.
    idle();
    tb_oe    = 1'b1;
    tb_drv   = 8'h3C;
    mem_load = 1'b1;
    addr     = 4'd7;
    tick();
    mem_read("write_a7", 4'd7, 8'h3C);
    mem_read("neighbour_a6", 4'd6, 8'h00);
    mem_read("top_a15", 4'd15, 8'h00);

    // Bus released with no enables: the testbench value passes through unaltered.
    idle();
    tb_oe  = 1'b1;
    tb_drv = 8'hA5;
    exp_bus("released", 8'hA5);
    tick();

    // Both enables: register wins over memory (addr1 = 0xE0).
    idle();
    reg_enable = 1'b1;
    mem_enable = 1'b1;
    addr       = 4'd1;
    exp_bus("both_enables", 8'h5A);
    tick();

    // Simultaneous register and memory load of the same bus value.
    idle();
    tb_oe    = 1'b1;
    tb_drv   = 8'h96;
    reg_load = 1'b1;
    mem_load = 1'b1;
    addr     = 4'd9;
    tick();
    idle();
    exp_reg("dual_load_reg", 8'h96);
    tick();
    mem_read("dual_load_mem", 4'd9, 8'h96);

    // Load while enabled reloads own value; low-nibble mode clears the upper nibble.
    idle();
    reg_load   = 1'b1;
    reg_enable = 1'b1;
    tick();
    idle();
    exp_reg("self_reload_full", 8'h96);
    tick();
    reg_load       = 1'b1;
    reg_enable     = 1'b1;
    reg_only_lower = 1'b1;
    tick();
    idle();
    exp_reg("self_reload_lower", 8'h06);
    tick();

    // Holds with no load.
    repeat (4) tick();
    exp_reg("hold_reg", 8'h06);
    mem_read("hold_mem", 4'd7, 8'h3C);

    // Spec scenario: reg 0x5A reloaded with load, enable and low-nibble all set.
    load_reg(8'h5A);
    reg_load       = 1'b1;
    reg_enable     = 1'b1;
    reg_only_lower = 1'b1;
    tick();
    idle();
    exp_reg("spec_lower_reload", 8'h0A);
    tick();

    // Async reset pulse between edges while the register drives the bus.
    load_reg(8'h5A);
    reg_enable = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    exp_reg("async_clear", 8'h00);
    exp_bus("reset_drive", 8'h00);
    tick();

    // Loads ignored while reset is held; memory untouched.
    idle();
    tb_oe    = 1'b1;
    tb_drv   = 8'hC3;
    reg_load = 1'b1;
    tick();
    idle();
    exp_reg("load_in_reset", 8'h00);
    mem_enable = 1'b1;
    exp_bus("mem_after_reset", 8'h5A);
    tick();
    rst = 1'b1;
    load_reg(8'hC3);
    exp_reg("load_after_release", 8'hC3);
    tick();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d pending expectations left, required 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
